// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Drives all 16 minterms of a 4-input logic function onto switches A..D,
//   waits SETTLE cycles after each change, samples the response and builds
//   the captured truth table while counting disagreements with a golden table.
//
// Parameters
//   SETTLE        wait cycles after each stimulus change before sampling (0..15)
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   start         request a full sweep (only honoured when idle)
//   expected      golden truth table, bit m = F(m)
//   f_in          response of the logic under test
//   abcd          stimulus {A,B,C,D}; minterm index m = abcd
//   busy          high while a sweep is running
//   done          one-cycle pulse when the sweep completes
//   table_out     captured truth table, bit m = f_in sampled at minterm m
//   mismatch_cnt  number of minterms where f_in differed from expected
//   pass          high when the completed sweep had no mismatches
module truth_table_sweeper #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_cnt,
  output logic        pass
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q,  state_d;
  logic [3:0]  abcd_q,   abcd_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] exp_q,    exp_d;
  logic [15:0] table_q,  table_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic        pass_q,   pass_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;

  logic [4:0]  cnt_next;

  always_comb begin
    state_d  = state_q;
    abcd_d   = abcd_q;
    settle_d = settle_q;
    exp_d    = exp_q;
    table_d  = table_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_next = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d    = expected;
          table_d  = '0;
          cnt_d    = '0;
          pass_d   = 1'b0;
          abcd_d   = '0;
          settle_d = SETTLE_L;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end

      RUN: begin
        if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else begin
          table_d[abcd_q] = f_in;
          if (f_in != exp_q[abcd_q]) begin
            cnt_next = cnt_q + 5'd1;
          end
          cnt_d = cnt_next;
          if (abcd_q == 4'hF) begin
            // pass uses the count including this final sample so it is
            // already valid in the cycle done is high
            pass_d  = (cnt_next == 5'd0);
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            abcd_d   = abcd_q + 4'd1;
            settle_d = SETTLE_L;
          end
        end
      end

      DONE: begin
        abcd_d  = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        abcd_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      abcd_q   <= '0;
      settle_q <= '0;
      exp_q    <= '0;
      table_q  <= '0;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      abcd_q   <= abcd_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      table_q  <= table_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign abcd         = abcd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign mismatch_cnt = cnt_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=2 and SETTLE=0) share
// stimulus; a minterm-timing model is compared every cycle and directed
// scenarios pin literal results.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] expected = '0;
  int          mode = 2;  // 0: f tied 0, 1: f tied 1, 2: formula

  logic [3:0]  abcd_o  [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic [15:0] table_o [2];
  logic [4:0]  cnt_o   [2];
  logic        pass_o  [2];
  logic        f_w     [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic f_of(int md, logic [3:0] m);
    logic a, b, c, d;
    {a, b, c, d} = m;
    case (md)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return (!a & b & !c) | (a & !b & !d) | (a & !b & !c) | (!c & !d);
    endcase
  endfunction

  function automatic int settle_of(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  assign f_w[0] = f_of(mode, abcd_o[0]);
  assign f_w[1] = f_of(mode, abcd_o[1]);

  truth_table_sweeper #(.SETTLE(2)) dut_s2 (
    .clk(clk), .reset(reset), .start(start), .expected(expected), .f_in(f_w[0]),
    .abcd(abcd_o[0]), .busy(busy_o[0]), .done(done_o[0]), .table_out(table_o[0]),
    .mismatch_cnt(cnt_o[0]), .pass(pass_o[0])
  );

  truth_table_sweeper #(.SETTLE(0)) dut_s0 (
    .clk(clk), .reset(reset), .start(start), .expected(expected), .f_in(f_w[1]),
    .abcd(abcd_o[1]), .busy(busy_o[1]), .done(done_o[1]), .table_out(table_o[1]),
    .mismatch_cnt(cnt_o[1]), .pass(pass_o[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: time since accept determines the minterm; sample m at
  // (m+1)*(SETTLE+1) edges after accept.
  logic        mb   [2] = '{1'b0, 1'b0};
  logic        md   [2] = '{1'b0, 1'b0};
  int          mt   [2] = '{0, 0};
  logic [15:0] mexp [2] = '{16'h0, 16'h0};
  logic [15:0] mtab [2] = '{16'h0, 16'h0};
  int          mcnt [2] = '{0, 0};
  logic        mpass[2] = '{1'b0, 1'b0};
  logic [3:0]  ma   [2] = '{4'h0, 4'h0};

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      int t, m, per, c;
      logic fv;
      per = settle_of(i) + 1;
      if (reset) begin
        mb[i] <= 1'b0; md[i] <= 1'b0; mt[i] <= 0; mtab[i] <= '0;
        mcnt[i] <= 0; mpass[i] <= 1'b0; ma[i] <= '0;
      end else if (md[i]) begin
        md[i] <= 1'b0;
        ma[i] <= '0;
      end else if (mb[i]) begin
        t = mt[i] + 1;
        mt[i] <= t;
        if (t % per == 0) begin
          m  = t / per - 1;
          fv = f_of(mode, 4'(m));
          c  = mcnt[i] + ((fv != mexp[i][m]) ? 1 : 0);
          mtab[i][m] <= fv;
          mcnt[i] <= c;
          if (m == 15) begin
            mb[i] <= 1'b0;
            md[i] <= 1'b1;
            mpass[i] <= (c == 0);
          end else begin
            ma[i] <= 4'(m + 1);
          end
        end
      end else if (start) begin
        mb[i] <= 1'b1; mt[i] <= 0; mexp[i] <= expected; mtab[i] <= '0;
        mcnt[i] <= 0; mpass[i] <= 1'b0; ma[i] <= '0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abcd[%0d]", i),  32'(abcd_o[i]),  32'(ma[i]));
      chk($sformatf("busy[%0d]", i),  32'(busy_o[i]),  32'(mb[i]));
      chk($sformatf("done[%0d]", i),  32'(done_o[i]),  32'(md[i]));
      chk($sformatf("table[%0d]", i), 32'(table_o[i]), 32'(mtab[i]));
      chk($sformatf("cnt[%0d]", i),   32'(cnt_o[i]),   32'(mcnt[i]));
      chk($sformatf("pass[%0d]", i),  32'(pass_o[i]),  32'(mpass[i]));
    end
  end

  task automatic pulse_start(output int acc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int i, input int acc, input int lat);
    int n;
    n = 0;
    while (!done_o[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_seen[%0d]", i), 32'(done_o[i]), 32'd1);
    chk($sformatf("done_latency[%0d]", i), 32'(cyc - acc), 32'(lat));
  endtask

  task automatic chk_res(input int i, input logic [15:0] tb, input int c, input logic p);
    chk($sformatf("res_table[%0d]", i), 32'(table_o[i]), 32'(tb));
    chk($sformatf("res_cnt[%0d]", i),   32'(cnt_o[i]),   32'(c));
    chk($sformatf("res_pass[%0d]", i),  32'(pass_o[i]),  32'(p));
  endtask

  initial begin
    int acc, pulses, n;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_abcd", 32'(abcd_o[0]), 32'd0);
    chk("reset_busy", 32'(busy_o[0]), 32'd0);
    chk("reset_table", 32'(table_o[0]), 32'd0);
    reset = 1'b0;

    // Formula response, matching golden table
    mode = 2; expected = 16'h1731;
    pulse_start(acc);
    wait_done(1, acc, 16);
    wait_done(0, acc, 48);
    chk_res(0, 16'h1731, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk_res(0, 16'h1731, 0, 1'b1);
    chk_res(1, 16'h1731, 0, 1'b1);

    // f tied low
    mode = 0;
    pulse_start(acc);
    wait_done(0, acc, 48);
    chk_res(0, 16'h0000, 7, 1'b0);
    chk_res(1, 16'h0000, 7, 1'b0);
    repeat (3) @(negedge clk);

    // f tied high, all-zero golden table
    mode = 1; expected = 16'h0000;
    pulse_start(acc);
    wait_done(1, acc, 16);
    chk_res(1, 16'hFFFF, 16, 1'b0);
    wait_done(0, acc, 48);
    chk_res(0, 16'hFFFF, 16, 1'b0);
    repeat (3) @(negedge clk);

    // start held high across the whole sweep
    mode = 2; expected = 16'h1731;
    @(negedge clk); start = 1'b1;
    @(negedge clk); acc = cyc;
    pulses = 0; n = 0;
    while (n < 200) begin
      if (done_o[0]) begin
        pulses++;
        break;
      end
      @(negedge clk);
      n++;
    end
    chk("held_latency", 32'(cyc - acc), 32'd48);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_o[0]) pulses++;
    end
    chk("held_done_pulses", 32'(pulses), 32'd1);
    chk("held_idle_busy", 32'(busy_o[0]), 32'd0);
    chk_res(0, 16'h1731, 0, 1'b1);
    repeat (40) @(negedge clk);

    // asynchronous reset mid-sweep at minterm 7
    pulse_start(acc);
    n = 0;
    while (abcd_o[0] != 4'd7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_m7", 32'(abcd_o[0]), 32'd7);
    chk("partial_table", 32'(table_o[0]), 32'h0031);
    #2 reset = 1'b1;
    #1;
    chk("rst_abcd", 32'(abcd_o[0]), 32'd0);
    chk("rst_busy", 32'(busy_o[0]), 32'd0);
    chk("rst_done", 32'(done_o[0]), 32'd0);
    chk("rst_table", 32'(table_o[0]), 32'd0);
    chk("rst_cnt", 32'(cnt_o[0]), 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    pulse_start(acc);
    wait_done(0, acc, 48);
    chk_res(0, 16'h1731, 0, 1'b1);
    repeat (3) @(negedge clk);

    // expected changes right after accept
    pulse_start(acc);
    expected = 16'h0000;
    wait_done(0, acc, 48);
    chk_res(0, 16'h1731, 0, 1'b1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, meaning wait cycles after each input change before sampling; legal range 0..15.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request a full 16-minterm sweep; sampled only in IDLE.
REQ-005 The block SHALL have port expected  input  16  golden truth table; bit m is F for minterm m.
REQ-006 The block SHALL have port f_in  input  1  response of the logic under test, the LED net.
REQ-007 The block SHALL have port abcd  output  4  stimulus driven to switches A,B,C,D; bit3=A, bit2=B, bit1=C, bit0=D; minterm index m={A,B,C,D}.
REQ-008 The block SHALL have port busy  output  1  high while a sweep is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-010 The block SHALL have port table_out  output  16  captured truth table; bit m is f_in sampled for minterm m.
REQ-011 The block SHALL have port mismatch_cnt  output  5  count of minterms where f_in differed from expected, 0..16.
REQ-012 The block SHALL have port pass  output  1  high when mismatch_cnt is 0 at sweep completion.

Function
REQ-013 The block SHALL implement states IDLE, RUN, DONE.
REQ-014 In IDLE with start=1 at an edge, the block SHALL latch expected, clear table_out, mismatch_cnt and pass to 0, set abcd=0, load settle counter with SETTLE, and enter RUN.
REQ-015 In RUN, at each edge with settle counter nonzero, the block SHALL decrement the counter and hold abcd.
REQ-016 In RUN, at an edge with settle counter zero, the block SHALL write f_in into table_out[abcd], increment mismatch_cnt if f_in differs from latched expected[abcd], and, if abcd<15, increment abcd and reload the counter with SETTLE.
REQ-017 When the sample of REQ-016 occurs with abcd=15, the block SHALL enter DONE instead of incrementing abcd; abcd never wraps to 0 within a sweep.
REQ-018 Each minterm SHALL occupy exactly SETTLE+1 cycles; DONE SHALL be entered on edge 16*(SETTLE+1) after the start-accept edge.
REQ-019 In DONE, done SHALL be high for exactly one cycle, with pass = (mismatch_cnt==0) already valid; the next edge SHALL return to IDLE and set abcd=0.
REQ-020 busy SHALL be high exactly while in RUN; done and busy SHALL never be high together.
REQ-021 start while in RUN or DONE SHALL be ignored; no restart, no clearing of results.
REQ-022 table_out, mismatch_cnt and pass SHALL hold their final values in IDLE until the next accepted start.
REQ-023 Changes on expected after the start-accept edge SHALL not affect the sweep.
REQ-024 With SETTLE=0, the block SHALL sample on every RUN edge, one minterm per cycle.

Reset
REQ-025 When reset=1, the block SHALL immediately, without a clock, force state IDLE, abcd=0, busy=0, done=0, table_out=0, mismatch_cnt=0, pass=0, settle counter=0.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; the first start after reset deasserts SHALL begin a fresh sweep at minterm 0.

Verification
REQ-027 Bench: SETTLE=2; f_in modelled as A'BC' + AB'D' + AB'C' + C'D' of abcd; expected=16'h1731; pulse start -> done on edge 48 after accept, table_out=16'h1731, mismatch_cnt=0, pass=1.
REQ-028 Bench: f_in tied 0, expected=16'h1731 -> table_out=16'h0000, mismatch_cnt=7, pass=0.
REQ-029 Bench: f_in tied 1, expected=16'h0000, SETTLE=0 -> done on edge 16 after accept, table_out=16'hFFFF, mismatch_cnt=16, pass=0.
REQ-030 Bench: start held high through the whole sweep of REQ-027 -> single done pulse, abcd steps 0..15 each held 3 cycles, results unchanged by start while busy; a new sweep begins only after return to IDLE.
REQ-031 Bench: assert reset while abcd=7 in RUN -> same cycle abcd=0, busy=0, table_out=0, mismatch_cnt=0, no done; a subsequent start gives the REQ-027 results.
REQ-032 Bench: change expected to 16'h0000 one cycle after start accept in REQ-027 setup -> results still table_out=16'h1731, mismatch_cnt=0, pass=1.
